// File: rtl/packet_ingress_arbiter_if.sv
// Flit type package and the flit handshake bundle between upstream channels,
// the ingress arbiter and the packet_buffer input.
package types;
    typedef enum logic [1:0] {
        NOPE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } flittype_t;

    typedef struct packed {
        flittype_t  flittype;
        logic [3:0] flit_num;
        logic [3:0] src;
    } header_t;

    typedef struct packed {
        header_t     header;
        logic [15:0] data;
    } flit_t;
endpackage

interface packet_ingress_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    types::flit_t           in_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0]   in_flit_valid;
    logic [NUM_PORTS-1:0]   in_flit_ready;
    types::flit_t           out_flit;
    logic                   out_flit_valid;
    logic                   out_flit_ready;

    modport master (
        output in_flit, in_flit_valid, out_flit_ready,
        input  in_flit_ready, out_flit, out_flit_valid
    );

    modport slave (
        input  in_flit, in_flit_valid, out_flit_ready,
        output in_flit_ready, out_flit, out_flit_valid
    );
endinterface

// File: rtl/packet_ingress_arbiter.sv
// Wormhole ingress arbiter: round-robin grant on HEAD flits, lock held until
// the owner's TAIL transfers or the owner stays idle for LOCK_TIMEOUT cycles.
module packet_ingress_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                           nocclk,
    input  logic                           rst_n,
    packet_ingress_arbiter_if.slave        bus,
    output logic [$clog2(NUM_PORTS)-1:0]   owner,
    output logic                           locked,
    output logic                           drop_pulse,
    output logic                           timeout_pulse
);
    import types::*;

    localparam int OW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state;
    logic [OW-1:0]        rr_ptr;
    logic [CW-1:0]        idle_cnt;

    logic [OW-1:0]        grant;
    logic                 grant_found;
    logic [NUM_PORTS-1:0] ready;
    logic [NUM_PORTS-1:0] fwd_ready;
    logic                 out_valid;
    logic                 drop;
    flit_t                out_data;
    flittype_t            owner_type;

    always_comb begin
        ready       = '0;
        fwd_ready   = '0;
        drop        = 1'b0;
        out_valid   = 1'b0;
        out_data    = bus.in_flit[owner];
        grant       = rr_ptr;
        grant_found = 1'b0;
        owner_type  = bus.in_flit[owner].header.flittype;

        // NOPEs are always swallowed; BODY/TAIL outside the owner's lock are orphans.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.in_flit_valid[p]) begin
                if (bus.in_flit[p].header.flittype == NOPE) begin
                    ready[p] = 1'b1;
                end else if (bus.in_flit[p].header.flittype != HEAD &&
                             !(state == LOCKED && OW'(p) == owner)) begin
                    ready[p] = 1'b1;
                    drop     = 1'b1;
                end
            end
        end

        if (state == IDLE) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!grant_found &&
                    bus.in_flit_valid[(int'(rr_ptr) + i) % NUM_PORTS] &&
                    bus.in_flit[(int'(rr_ptr) + i) % NUM_PORTS].header.flittype == HEAD) begin
                    grant_found = 1'b1;
                    grant       = OW'((int'(rr_ptr) + i) % NUM_PORTS);
                end
            end
            if (grant_found) begin
                out_data         = bus.in_flit[grant];
                out_valid        = 1'b1;
                ready[grant]     = bus.out_flit_ready;
                fwd_ready[grant] = bus.out_flit_ready;
            end
        end else if (bus.in_flit_valid[owner] && owner_type != NOPE) begin
            out_valid        = 1'b1;
            ready[owner]     = bus.out_flit_ready;
            fwd_ready[owner] = bus.out_flit_ready;
        end

        // Reset blanks the handshake outputs immediately, not at the next edge.
        if (!rst_n) begin
            ready     = '0;
            fwd_ready = '0;
            drop      = 1'b0;
            out_valid = 1'b0;
        end
    end

    assign bus.in_flit_ready  = ready;
    assign bus.out_flit_valid = out_valid;
    assign bus.out_flit       = out_data;
    assign drop_pulse         = drop;
    assign locked             = (state == LOCKED);

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found && bus.out_flit_ready) begin
                        state    <= LOCKED;
                        owner    <= grant;
                        rr_ptr   <= OW'((int'(grant) + 1) % NUM_PORTS);
                        idle_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (out_valid && bus.out_flit_ready) begin
                        idle_cnt <= '0;
                        if (owner_type == TAIL) begin
                            state <= IDLE;
                        end
                    end else if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state         <= IDLE;
                        idle_cnt      <= '0;
                        timeout_pulse <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_fwd_onehot: assert property (@(posedge nocclk) disable iff (!rst_n) $onehot0(fwd_ready));

endmodule

// File: tb/tb_packet_ingress_arbiter.sv
// Directed bench for packet_ingress_arbiter (4 ports, lock timeout of 4 cycles).
module tb_packet_ingress_arbiter;
    import types::*;

    localparam int NP = 4;
    localparam int TO = 4;

    logic        nocclk = 1'b0;
    logic        rst_n;
    logic [1:0]  owner;
    logic        locked;
    logic        drop_pulse;
    logic        timeout_pulse;
    int          checks = 0;
    int          errors = 0;

    packet_ingress_arbiter_if #(.NUM_PORTS(NP)) bus ();

    packet_ingress_arbiter #(.NUM_PORTS(NP), .LOCK_TIMEOUT(TO)) dut (
        .nocclk        (nocclk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .owner         (owner),
        .locked        (locked),
        .drop_pulse    (drop_pulse),
        .timeout_pulse (timeout_pulse)
    );

    always #5 nocclk = ~nocclk;

    function automatic flit_t mk(flittype_t t, logic [3:0] n, logic [3:0] s, logic [15:0] d);
        flit_t f;
        f.header.flittype = t;
        f.header.flit_num = n;
        f.header.src      = s;
        f.data            = d;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input flit_t f);
        bus.in_flit_valid[p] = v;
        bus.in_flit[p]       = f;
    endtask

    task automatic tick();
        @(posedge nocclk);
        #1;
    endtask

    task automatic idle_all();
        bus.in_flit_valid = '0;
    endtask

    flit_t h0, b0, t0, h1, b1, t1, h2, t2, h3, b3;

    initial begin
        h0 = mk(HEAD, 4'd0, 4'd0, 16'hA000);
        b0 = mk(BODY, 4'd1, 4'd0, 16'hA001);
        t0 = mk(TAIL, 4'd2, 4'd0, 16'hA002);
        h1 = mk(HEAD, 4'd0, 4'd1, 16'hB000);
        b1 = mk(BODY, 4'd1, 4'd1, 16'hB001);
        t1 = mk(TAIL, 4'd2, 4'd1, 16'hB002);
        h2 = mk(HEAD, 4'd0, 4'd2, 16'hC000);
        t2 = mk(TAIL, 4'd1, 4'd2, 16'hC001);
        h3 = mk(HEAD, 4'd0, 4'd3, 16'hD000);
        b3 = mk(BODY, 4'd1, 4'd3, 16'hD001);

        rst_n              = 1'b0;
        bus.out_flit_ready = 1'b1;
        for (int p = 0; p < NP; p++) drive(p, 1'b0, '0);
        #3;
        chk("rst_out_valid", bus.out_flit_valid, 0);
        chk("rst_ready", bus.in_flit_ready, 4'b0000);
        chk("rst_locked", locked, 0);
        chk("rst_owner", owner, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_timeout", timeout_pulse, 0);
        repeat (2) @(posedge nocclk);
        #1 rst_n = 1'b1;
        tick();

        // Single packet on port 0
        drive(0, 1'b1, h0); #2;
        chk("t1_head_valid", bus.out_flit_valid, 1);
        chk("t1_head_flit", bus.out_flit, h0);
        chk("t1_head_ready", bus.in_flit_ready, 4'b0001);
        chk("t1_head_locked", locked, 0);
        tick();
        drive(0, 1'b1, b0); #2;
        chk("t1_body_locked", locked, 1);
        chk("t1_body_flit", bus.out_flit, b0);
        chk("t1_body_ready", bus.in_flit_ready, 4'b0001);
        tick();
        drive(0, 1'b1, t0); #2;
        chk("t1_tail_locked", locked, 1);
        chk("t1_tail_flit", bus.out_flit, t0);
        chk("t1_tail_ready", bus.in_flit_ready, 4'b0001);
        tick();
        idle_all(); #2;
        chk("t1_after_locked", locked, 0);
        chk("t1_after_valid", bus.out_flit_valid, 0);
        tick();

        // Ports 1 and 2 contend
        drive(1, 1'b1, h1); drive(2, 1'b1, h2); #2;
        chk("t2_grant1_ready", bus.in_flit_ready, 4'b0010);
        chk("t2_grant1_flit", bus.out_flit, h1);
        tick();
        drive(1, 1'b1, b1); #2;
        chk("t2_p1_body_ready", bus.in_flit_ready, 4'b0010);
        chk("t2_p1_owner", owner, 1);
        chk("t2_p1_locked", locked, 1);
        tick();
        drive(1, 1'b1, t1); #2;
        chk("t2_p1_tail_ready", bus.in_flit_ready, 4'b0010);
        tick();
        drive(1, 1'b0, '0); #2;
        chk("t2_bubble_locked", locked, 0);
        chk("t2_grant2_ready", bus.in_flit_ready, 4'b0100);
        chk("t2_grant2_flit", bus.out_flit, h2);
        tick();
        drive(2, 1'b1, t2); #2;
        chk("t2_p2_owner", owner, 2);
        chk("t2_rr_ptr", dut.rr_ptr, 3);
        chk("t2_p2_tail_ready", bus.in_flit_ready, 4'b0100);
        tick();
        idle_all(); tick();

        // Orphan BODY on port 3 while port 0 is locked
        drive(0, 1'b1, h0); #2;
        chk("t3_head_ready", bus.in_flit_ready, 4'b0001);
        tick();
        drive(0, 1'b1, b0); drive(3, 1'b1, b3); #2;
        chk("t3_drop_ready", bus.in_flit_ready, 4'b1001);
        chk("t3_drop_pulse", drop_pulse, 1);
        chk("t3_drop_flit", bus.out_flit, b0);
        chk("t3_drop_valid", bus.out_flit_valid, 1);
        tick();
        drive(0, 1'b1, t0); drive(3, 1'b0, '0); #2;
        chk("t3_nodrop", drop_pulse, 0);
        chk("t3_tail_ready", bus.in_flit_ready, 4'b0001);
        tick();
        idle_all(); tick();

        // Lock timeout with port 1 HEAD pending
        drive(0, 1'b1, h0); #2;
        chk("t4_head_ready", bus.in_flit_ready, 4'b0001);
        tick();
        drive(0, 1'b0, '0); drive(1, 1'b1, h1);
        for (int i = 0; i < TO; i++) begin
            #2;
            chk("t4_wait_locked", locked, 1);
            chk("t4_wait_ready", bus.in_flit_ready, 4'b0000);
            chk("t4_wait_timeout", timeout_pulse, 0);
            tick();
        end
        #2;
        chk("t4_released", locked, 0);
        chk("t4_timeout_pulse", timeout_pulse, 1);
        chk("t4_grant1_ready", bus.in_flit_ready, 4'b0010);
        chk("t4_grant1_flit", bus.out_flit, h1);
        tick();
        drive(1, 1'b1, t1); #2;
        chk("t4_pulse_gone", timeout_pulse, 0);
        chk("t4_owner1", owner, 1);
        tick();
        idle_all(); tick();

        // Downstream stall with port 2 HEAD pending, port 0 HEAD arrives late
        bus.out_flit_ready = 1'b0;
        drive(2, 1'b1, h2); #2;
        chk("t5_s1_valid", bus.out_flit_valid, 1);
        chk("t5_s1_flit", bus.out_flit, h2);
        chk("t5_s1_ready", bus.in_flit_ready, 4'b0000);
        tick();
        drive(0, 1'b1, h0); #2;
        chk("t5_s2_flit", bus.out_flit, h2);
        chk("t5_s2_locked", locked, 0);
        tick(); #2;
        chk("t5_s3_flit", bus.out_flit, h2);
        chk("t5_s3_locked", locked, 0);
        tick();
        bus.out_flit_ready = 1'b1; #2;
        chk("t5_go_ready", bus.in_flit_ready, 4'b0100);
        chk("t5_go_flit", bus.out_flit, h2);
        tick();
        drive(2, 1'b1, t2); #2;
        chk("t5_owner2", owner, 2);
        chk("t5_locked", locked, 1);
        chk("t5_tail_ready", bus.in_flit_ready, 4'b0100);
        tick();
        idle_all(); tick();

        // Reset in the middle of a port 1 packet
        drive(1, 1'b1, h1); #2;
        chk("t6_head_ready", bus.in_flit_ready, 4'b0010);
        tick();
        drive(1, 1'b1, b1); #2;
        chk("t6_locked", locked, 1);
        drive(0, 1'b1, h0);
        rst_n = 1'b0; #1;
        chk("t6_rst_valid", bus.out_flit_valid, 0);
        chk("t6_rst_ready", bus.in_flit_ready, 4'b0000);
        chk("t6_rst_locked", locked, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 1'b0, '0); drive(3, 1'b1, h3); #2;
        chk("t6_post_ready", bus.in_flit_ready, 4'b0001);
        chk("t6_post_flit", bus.out_flit, h0);
        chk("t6_post_owner", owner, 0);
        tick(); #2;
        chk("t6_post_locked", locked, 1);
        chk("t6_post_owner0", owner, 0);
        idle_all();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
